// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
package flute_axi_pkg;

    localparam int         ARB_ADDR_W     = 32;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         ID_INST        = 0;
    localparam int         ID_DATA        = 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_e;

    typedef struct packed {
        logic [ARB_ADDR_W-1:0] addr;
        logic [3:0]            len;
        logic [2:0]            size;
    } rd_req_t;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI3 read-address and read-data channels between the arbiter (master) and the bus (slave).
interface axi_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [1:0]        arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_rd_arbiter_pick.sv
// Combinational two-way picker producing a one-hot grant.
// AXI_RD_ARB_RR_EN selects round-robin (ptr = last winner); otherwise bit 1 always wins.
module arb2_pick (
    input  logic [1:0] req,
`ifdef AXI_RD_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
`ifdef AXI_RD_ARB_RR_EN
        // On contention the requester that did not win last time goes first.
        if (req == 2'b11) begin
            grant = ptr ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
`else
        if (req[1]) begin
            grant = 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end
`endif
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI3 read channel between instruction fetch (m0) and data load (m1), one burst at a time.
// Build option AXI_RD_ARB_RR_EN: round-robin arbitration instead of fixed m1-first priority.
module axi_rd_arbiter
    import flute_axi_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              m0_req,
    output logic              m0_ack,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_len,
    input  logic [2:0]        m0_size,
    output logic              m0_rvalid,
    input  logic              m0_rready,

    input  logic              m1_req,
    output logic              m1_ack,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_len,
    input  logic [2:0]        m1_size,
    output logic              m1_rvalid,
    input  logic              m1_rready,

    output logic [DATA_W-1:0] m_rdata,
    output logic              m_rlast,

    axi_rd_arbiter_if.master  axi,

    output logic              err
);

    arb_state_e      state_reg, state_next;
    rd_req_t         req_reg;
    logic            owner_reg;
    logic [3:0]      beat_cnt_reg;
    logic            err_reg;
    logic [1:0]      grant;
    logic            in_data;
    logic            r_hs;
    logic            r_stray;
    logic            beat_err;
    logic [ID_W-1:0] owner_id;
    logic            unused_rresp;

`ifdef AXI_RD_ARB_RR_EN
    logic            ptr_reg;

    arb2_pick u_pick (
        .req   ({m1_req, m0_req}),
        .ptr   (ptr_reg),
        .grant (grant)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_reg <= 1'b0;
        end else if (r_hs && axi.rlast) begin
            ptr_reg <= owner_reg;
        end
    end
`else
    arb2_pick u_pick (
        .req   ({m1_req, m0_req}),
        .grant (grant)
    );
`endif

    always_comb begin
        state_next = state_reg;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        case (state_reg)
            ARB_IDLE: begin
                if ((grant != 2'b00) && !reset) begin
                    m0_ack     = grant[0];
                    m1_ack     = grant[1];
                    state_next = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (axi.arready) begin
                    state_next = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (r_hs && axi.rlast) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign owner_id    = owner_reg ? ID_W'(ID_DATA) : ID_W'(ID_INST);

    assign axi.arid    = owner_id;
    assign axi.araddr  = req_reg.addr;
    assign axi.arlen   = req_reg.len;
    assign axi.arsize  = req_reg.size;
    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (state_reg == ARB_ADDR);

    assign in_data     = (state_reg == ARB_DATA);
    assign axi.rready  = in_data && (owner_reg ? m1_rready : m0_rready);
    assign m0_rvalid   = in_data && !owner_reg && axi.rvalid;
    assign m1_rvalid   = in_data &&  owner_reg && axi.rvalid;
    assign m_rdata     = axi.rdata;
    assign m_rlast     = axi.rlast;
    assign err         = err_reg;

    assign r_hs        = axi.rvalid && axi.rready;
    assign r_stray     = axi.rvalid && !in_data;
    // rlast must coincide exactly with the beat whose count equals len.
    assign beat_err    = (axi.rid != owner_id) || (axi.rlast != (beat_cnt_reg == req_reg.len));

    // Response status is not used by the caches.
    assign unused_rresp = ^axi.rresp;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ARB_IDLE;
            req_reg      <= '0;
            owner_reg    <= 1'b0;
            beat_cnt_reg <= 4'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ARB_IDLE) && (grant != 2'b00)) begin
                owner_reg <= grant[1];
                if (grant[1]) begin
                    req_reg <= '{addr: m1_addr, len: m1_len, size: m1_size};
                end else begin
                    req_reg <= '{addr: m0_addr, len: m0_len, size: m0_size};
                end
            end
            if (state_reg == ARB_IDLE) begin
                beat_cnt_reg <= 4'd0;
            end else if (r_hs) begin
                beat_cnt_reg <= beat_cnt_reg + 4'd1;
            end
            if ((r_hs && beat_err) || r_stray) begin
                err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: hand-computed expectations, one line per transaction.
module tb_axi_rd_arbiter;
    import flute_axi_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              m0_req = 1'b0, m1_req = 1'b0;
    logic              m0_ack, m1_ack;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [3:0]        m0_len = '0, m1_len = '0;
    logic [2:0]        m0_size = '0, m1_size = '0;
    logic              m0_rvalid, m1_rvalid;
    logic              m0_rready = 1'b0, m1_rready = 1'b0;
    logic [DATA_W-1:0] m_rdata;
    logic              m_rlast;
    logic              err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_ack    (m0_ack),
        .m0_addr   (m0_addr),
        .m0_len    (m0_len),
        .m0_size   (m0_size),
        .m0_rvalid (m0_rvalid),
        .m0_rready (m0_rready),
        .m1_req    (m1_req),
        .m1_ack    (m1_ack),
        .m1_addr   (m1_addr),
        .m1_len    (m1_len),
        .m1_size   (m1_size),
        .m1_rvalid (m1_rvalid),
        .m1_rready (m1_rready),
        .m_rdata   (m_rdata),
        .m_rlast   (m_rlast),
        .axi       (bus),
        .err       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    // Raise one requester's req, expect its ack in the same cycle, drop req after the ack edge.
    task automatic request(input int who, input logic [31:0] addr, input logic [3:0] len);
        if (who == 0) begin
            m0_req = 1'b1; m0_addr = addr; m0_len = len; m0_size = 3'd2;
        end else begin
            m1_req = 1'b1; m1_addr = addr; m1_len = len; m1_size = 3'd2;
        end
        #1;
        chk("ack_win",  (who == 0) ? m0_ack : m1_ack, 1);
        chk("ack_lose", (who == 0) ? m1_ack : m0_ack, 0);
        cyc();
        if (who == 0) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    // Entered in ADDR: accept the address, return beats 0..last_at, expect IDLE afterwards.
    task automatic serve(input int who, input logic [31:0] addr, input logic [3:0] len,
                         input logic [ID_W-1:0] rid_used, input int last_at);
        #1;
        chk("arvalid", bus.arvalid, 1);
        chk("arid",    bus.arid, 64'(who));
        chk("araddr",  bus.araddr, addr);
        chk("arlen",   bus.arlen, len);
        chk("arsize",  bus.arsize, 2);
        chk("arburst", bus.arburst, 1);
        bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0;
        m0_rready = (who == 0);
        m1_rready = (who == 1);
        for (int i = 0; i <= last_at; i++) begin
            bus.rvalid = 1'b1;
            bus.rid    = rid_used;
            bus.rdata  = 32'hD000_0000 + i;
            bus.rlast  = (i == last_at);
            #1;
            chk("rv_owner", (who == 0) ? m0_rvalid : m1_rvalid, 1);
            chk("rv_other", (who == 0) ? m1_rvalid : m0_rvalid, 0);
            chk("rready",   bus.rready, 1);
            chk("rdata",    m_rdata, 32'hD000_0000 + i);
            chk("rlast",    m_rlast, (i == last_at));
            cyc();
        end
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        #1;
        chk("idle",   dut.state_reg, ARB_IDLE);
        chk("bubble", bus.arvalid, 0);
        $display("txn owner=m%0d addr=%08h len=%0d beats=%0d err=%0d", who, addr, len, last_at + 1, err);
    endtask

    initial begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
        bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00;

        // Reset state, with a request pending that must not be acked during reset.
        m0_req = 1'b1;
        cyc(); cyc();
        #1;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready",  bus.rready, 0);
        chk("rst_err",     err, 0);
        chk("rst_ack0",    m0_ack, 0);
        chk("rst_ack1",    m1_ack, 0);
        chk("rst_rvalid0", m0_rvalid, 0);
        chk("rst_state",   dut.state_reg, ARB_IDLE);
        m0_req = 1'b0;
        reset  = 1'b0;
        cyc();

        // Single instruction fetch burst.
        request(0, 32'hBFC0_0000, 4'd3);
        serve(0, 32'hBFC0_0000, 4'd3, 4'd0, 3);
        chk("t1_err", err, 0);

        // Simultaneous requests: m1 wins first either way (reset pointer names m0 as last winner).
        m0_req = 1'b1; m0_addr = 32'h0000_1000; m0_len = 4'd0; m0_size = 3'd2;
        m1_req = 1'b1; m1_addr = 32'h0000_2000; m1_len = 4'd0; m1_size = 3'd2;
        #1;
        chk("t2_ack1", m1_ack, 1);
        chk("t2_ack0", m0_ack, 0);
        cyc();
        m1_req = 1'b0;
        #1;
        chk("t2_busy_ack0", m0_ack, 0);
        serve(1, 32'h0000_2000, 4'd0, 4'd1, 0);
        chk("t2_loser_ack", m0_ack, 1);
        cyc();
        m0_req = 1'b0;
        serve(0, 32'h0000_1000, 4'd0, 4'd0, 0);

        // m1 alone, then contention: fixed picks m1 again, round-robin picks m0.
        request(1, 32'h0000_2100, 4'd0);
        serve(1, 32'h0000_2100, 4'd0, 4'd1, 0);
        m0_req = 1'b1; m0_addr = 32'h0000_1100; m0_len = 4'd0;
        m1_req = 1'b1; m1_addr = 32'h0000_2200; m1_len = 4'd0;
        #1;
`ifdef AXI_RD_ARB_RR_EN
        chk("t2_rr_ack0", m0_ack, 1);
        chk("t2_rr_ack1", m1_ack, 0);
        cyc();
        m0_req = 1'b0;
        serve(0, 32'h0000_1100, 4'd0, 4'd0, 0);
        cyc();
        m1_req = 1'b0;
        serve(1, 32'h0000_2200, 4'd0, 4'd1, 0);
`else
        chk("t2_fx_ack1", m1_ack, 1);
        chk("t2_fx_ack0", m0_ack, 0);
        cyc();
        m1_req = 1'b0;
        serve(1, 32'h0000_2200, 4'd0, 4'd1, 0);
        cyc();
        m0_req = 1'b0;
        serve(0, 32'h0000_1100, 4'd0, 4'd0, 0);
`endif

        // arready stalled for five cycles with req still held.
        m0_req = 1'b1; m0_addr = 32'h8000_0040; m0_len = 4'd7; m0_size = 3'd2;
        #1;
        chk("t3_ack", m0_ack, 1);
        cyc();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t3_arvalid", bus.arvalid, 1);
            chk("t3_araddr",  bus.araddr, 32'h8000_0040);
            chk("t3_arlen",   bus.arlen, 7);
            chk("t3_noack",   m0_ack, 0);
            cyc();
        end
        m0_req = 1'b0;
        serve(0, 32'h8000_0040, 4'd7, 4'd0, 7);

        // m1_rready toggling: rready follows it, counter moves only on handshakes.
        begin
            int beat;
            beat = 0;
            request(1, 32'h0000_3000, 4'd3);
            #1;
            chk("t4_arvalid", bus.arvalid, 1);
            bus.arready = 1'b1;
            cyc();
            bus.arready = 1'b0;
            m0_rready = 1'b0;
            for (int k = 0; k < 7; k++) begin
                m1_rready  = (k % 2 == 0);
                bus.rvalid = 1'b1;
                bus.rid    = 4'd1;
                bus.rdata  = 32'h200 + beat;
                bus.rlast  = (beat == 3);
                #1;
                chk("t4_rready", bus.rready, (k % 2 == 0));
                chk("t4_cnt",    dut.beat_cnt_reg, beat);
                chk("t4_rvalid", m1_rvalid, 1);
                chk("t4_rdata",  m_rdata, 32'h200 + beat);
                cyc();
                if (k % 2 == 0) beat++;
            end
            bus.rvalid = 1'b0;
            bus.rlast  = 1'b0;
            #1;
            chk("t4_idle", dut.state_reg, ARB_IDLE);
            chk("t4_err",  err, 0);
            $display("txn owner=m1 addr=00003000 len=3 beats=%0d err=%0d (throttled)", beat, err);
        end

        // Early rlast sets err; transaction still ends.
        request(0, 32'h0000_4000, 4'd3);
        serve(0, 32'h0000_4000, 4'd3, 4'd0, 2);
        chk("t5_early_err", err, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("t5_rst_err", err, 0);

        // Stray beat in IDLE.
        bus.rvalid = 1'b1;
        #1;
        chk("t5_stray_rready", bus.rready, 0);
        chk("t5_stray_rv0",    m0_rvalid, 0);
        cyc();
        bus.rvalid = 1'b0;
        #1;
        chk("t5_stray_err", err, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;

        // Wrong rid on an m1 burst, then a clean m0 burst with err staying set.
        request(1, 32'h0000_5000, 4'd1);
        serve(1, 32'h0000_5000, 4'd1, 4'd0, 1);
        chk("t5_rid_err", err, 1);
        request(0, 32'h0000_6000, 4'd0);
        serve(0, 32'h0000_6000, 4'd0, 4'd0, 0);
        chk("t5_sticky", err, 1);

        // Reset in the middle of a data burst.
        request(1, 32'h0000_7000, 4'd3);
        bus.arready = 1'b1;
        cyc();
        bus.arready = 1'b0;
        m1_rready  = 1'b1;
        bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'h77; bus.rlast = 1'b0;
        cyc();
        #1;
        chk("t6_in_data", dut.state_reg, ARB_DATA);
        reset = 1'b1;
        cyc();
        reset      = 1'b0;
        bus.rvalid = 1'b0;
        #1;
        chk("t6_arvalid", bus.arvalid, 0);
        chk("t6_rready",  bus.rready, 0);
        chk("t6_err",     err, 0);
        chk("t6_state",   dut.state_reg, ARB_IDLE);
        request(0, 32'h0000_8000, 4'd1);
        serve(0, 32'h0000_8000, 4'd1, 4'd0, 1);
        chk("t6_err_after", err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
